// File: rtl/pdp8_mem_pkg.sv
// Shared definitions for the PDP-8 RAM port arbiter: port indices, sequencer states, access latch.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pdp8_mem_pkg;

  localparam int MA_W = 15;
  localparam int WD_W = 12;

  localparam logic [1:0] PORT_CPU  = 2'd0;
  localparam logic [1:0] PORT_RF   = 2'd1;
  localparam logic [1:0] PORT_DMA2 = 2'd2;
  localparam logic [1:0] PORT_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // One latched access: owner, direction, address and write data.
  typedef struct packed {
    logic [1:0]      port;
    logic            wr;
    logic [MA_W-1:0] ma;
    logic [WD_W-1:0] wd;
  } acc_t;

  // Completion strobe vector for a port index; PORT_NONE maps to no strobe.
  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    oh = 3'b000;
    case (p)
      PORT_CPU:  oh = 3'b001;
      PORT_RF:   oh = 3'b010;
      PORT_DMA2: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pdp8_ram_arb_pick.sv
// Winner select for the shared RAM port: DMA ports round-robin, DMA over CPU, CPU forced after a burst.
// Latency: purely combinational, evaluated by the sequencer only while idle.
// Backpressure: none here; losers simply keep their request level asserted.
module pdp8_ram_arb_pick
  import pdp8_mem_pkg::*;
#(
  parameter int DMA_BURST = 4
) (
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  input  logic [3:0] burst_cnt,
  output logic [1:0] win
);

  logic       cpu_forced;
  logic [1:0] dma_pick;

  // CPU gets its guaranteed slot once the DMA run while it waited reaches the burst limit.
  assign cpu_forced = req[0] && (burst_cnt >= 4'(DMA_BURST));

  // Pick among DMA ports; the pointer only matters when both are asking.
  always_comb begin
    dma_pick = PORT_NONE;
    if (req[1] && req[2]) begin
      dma_pick = rr_ptr;
    end else if (req[1]) begin
      dma_pick = PORT_RF;
    end else if (req[2]) begin
      dma_pick = PORT_DMA2;
    end
  end

  // Final winner: forced CPU slot, else any DMA, else CPU, else nobody.
  always_comb begin
    win = PORT_NONE;
    if (cpu_forced) begin
      win = PORT_CPU;
    end else if (dma_pick != PORT_NONE) begin
      win = dma_pick;
    end else if (req[0]) begin
      win = PORT_CPU;
    end
  end

endmodule

// File: rtl/pdp8_ram_arb.sv
// Three-port arbiter/sequencer sharing one 15-bit x 12-bit RAM port between CPU, RF and a spare DMA port.
// Latency: IDLE->ISSUE->WAIT->DONE, so rq_done lands in the 4th cycle when the RAM answers in the first WAIT cycle.
// Backpressure: requesters hold their level until their rq_done bit; a silent RAM is abandoned after TIMEOUT cycles.
module pdp8_ram_arb
  import pdp8_mem_pkg::*;
#(
  parameter int          DMA_BURST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      rq_read,
  input  logic [2:0]      rq_write,
  input  logic [MA_W-1:0] rq_ma0,
  input  logic [MA_W-1:0] rq_ma1,
  input  logic [MA_W-1:0] rq_ma2,
  input  logic [WD_W-1:0] rq_wd0,
  input  logic [WD_W-1:0] rq_wd1,
  input  logic [WD_W-1:0] rq_wd2,
  output logic [2:0]      rq_done,
  output logic [WD_W-1:0] rq_rd,
  output logic            rq_err,
  output logic            mem_read_req,
  output logic            mem_write_req,
  output logic [MA_W-1:0] mem_ma,
  output logic [WD_W-1:0] mem_out,
  input  logic [WD_W-1:0] mem_in,
  input  logic            mem_done,
  output logic [1:0]      grant
);

  arb_state_t state;
  acc_t       acc;
  acc_t       nxt_acc;
  logic [2:0] req_any;
  logic [1:0] win;
  logic [1:0] rr_ptr;
  logic [3:0] burst_cnt;
  logic [7:0] tcnt;
  logic       timed_out;

  // A port asking for both directions is treated as a write.
  assign req_any = rq_read | rq_write;

  pdp8_ram_arb_pick #(
    .DMA_BURST(DMA_BURST)
  ) u_pick (
    .req      (req_any),
    .rr_ptr   (rr_ptr),
    .burst_cnt(burst_cnt),
    .win      (win)
  );

  // tcnt counts cycles the RAM request has been up, starting with the ISSUE cycle.
  assign timed_out = (TIMEOUT != 0) && (({1'b0, tcnt} + 9'd1) >= 9'(TIMEOUT));

  // Capture the winning port's address, data and direction for latching.
  always_comb begin
    nxt_acc      = '0;
    nxt_acc.port = win;
    case (win)
      PORT_CPU: begin
        nxt_acc.wr = rq_write[0];
        nxt_acc.ma = rq_ma0;
        nxt_acc.wd = rq_wd0;
      end
      PORT_RF: begin
        nxt_acc.wr = rq_write[1];
        nxt_acc.ma = rq_ma1;
        nxt_acc.wd = rq_wd1;
      end
      PORT_DMA2: begin
        nxt_acc.wr = rq_write[2];
        nxt_acc.ma = rq_ma2;
        nxt_acc.wd = rq_wd2;
      end
      default: nxt_acc.port = PORT_NONE;
    endcase
  end

  // Access sequencer with registered RAM/requester outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      acc           <= '0;
      grant         <= PORT_NONE;
      rr_ptr        <= PORT_RF;
      burst_cnt     <= 4'd0;
      tcnt          <= 8'd0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      mem_ma        <= '0;
      mem_out       <= '0;
      rq_done       <= 3'b000;
      rq_err        <= 1'b0;
      rq_rd         <= '0;
    end else begin
      rq_done <= 3'b000;
      rq_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Burst count only tracks DMA wins that actually made the CPU wait.
          if (!req_any[0] || win == PORT_CPU) begin
            burst_cnt <= 4'd0;
          end else if (win != PORT_NONE && burst_cnt != 4'hF) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
          if (win != PORT_NONE) begin
            acc           <= nxt_acc;
            grant         <= win;
            tcnt          <= 8'd0;
            mem_read_req  <= !nxt_acc.wr;
            mem_write_req <= nxt_acc.wr;
            mem_ma        <= nxt_acc.ma;
            mem_out       <= nxt_acc.wr ? nxt_acc.wd : '0;
            state         <= ST_ISSUE;
            if (win == PORT_RF) begin
              rr_ptr <= PORT_DMA2;
            end else if (win == PORT_DMA2) begin
              rr_ptr <= PORT_RF;
            end
          end
        end
        ST_ISSUE: begin
          tcnt  <= tcnt + 8'd1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_done) begin
            if (!acc.wr) begin
              rq_rd <= mem_in;
            end
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            rq_done       <= port_onehot(acc.port);
            grant         <= PORT_NONE;
            state         <= ST_DONE;
          end else if (timed_out) begin
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            rq_done       <= port_onehot(acc.port);
            rq_err        <= 1'b1;
            grant         <= PORT_NONE;
            state         <= ST_DONE;
          end else if (tcnt != 8'hFF) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
